// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters producing the next fetch PC.
// Optional BP_STATS_EN adds saturating update/redirect cycle counters.
module branch_predictor #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              hit_o,
  output logic              pred_taken_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_upd_cnt_o,
  output logic [31:0]       stat_redir_cnt_o
`endif
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic [N-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q    [N], tag_d    [N];
  logic [ADDR_W-1:0] target_q [N], target_d [N];
  logic [1:0]        ctr_q    [N], ctr_d    [N];
  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;
  logic              unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc_i[1:0], upd_pc_i[1:0]};
  assign lk_idx = pc_i[IDX_W+1:2];
  assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  always_comb begin
    hit_o        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o = hit_o && ctr_q[lk_idx][1];
    next_pc_o    = redirect_i   ? redirect_pc_i :
                   pred_taken_o ? target_q[lk_idx] : pc_i + ADDR_W'(4);
  end
  // Table updates: hits train the counter, taken misses (re)allocate weakly taken.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    if (upd_valid_i && up_hit) begin
      ctr_d[up_idx] = upd_taken_i ? ((ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01)
                                  : ((ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01);
      if (upd_taken_i) target_d[up_idx] = upd_target_i;
    end else if (upd_valid_i && upd_taken_i) begin
      valid_d[up_idx]  = 1'b1;
      tag_d[up_idx]    = up_tag;
      target_d[up_idx] = upd_target_i;
      ctr_d[up_idx]    = 2'b10;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end
`ifdef BP_STATS_EN
  logic [31:0] upd_cnt_q, upd_cnt_d, redir_cnt_q, redir_cnt_d;
  always_comb begin
    upd_cnt_d   = (upd_valid_i && upd_cnt_q != '1) ? upd_cnt_q + 32'd1 : upd_cnt_q;
    redir_cnt_d = (redirect_i && redir_cnt_q != '1) ? redir_cnt_q + 32'd1 : redir_cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_cnt_q   <= '0;
      redir_cnt_q <= '0;
    end else begin
      upd_cnt_q   <= upd_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end
  assign stat_upd_cnt_o   = upd_cnt_q;
  assign stat_redir_cnt_o = redir_cnt_q;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, redirect and async reset.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0, redirect_pc_i = '0, upd_pc_i = '0, upd_target_i = '0;
  logic        redirect_i = 1'b0, upd_valid_i = 1'b0, upd_taken_i = 1'b0;
  logic [31:0] next_pc_o;
  logic        hit_o, pred_taken_o;
  int          pass = 0, total = 0;
`ifdef BP_STATS_EN
  logic [31:0] stat_upd_cnt_o, stat_redir_cnt_o;
`endif
  branch_predictor #(.IDX_W(4), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i), .next_pc_o(next_pc_o),
    .hit_o(hit_o), .pred_taken_o(pred_taken_o)
`ifdef BP_STATS_EN
    , .stat_upd_cnt_o(stat_upd_cnt_o), .stat_redir_cnt_o(stat_redir_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    @(negedge clk);
    upd_valid_i = 1'b1; upd_pc_i = pc; upd_taken_i = taken; upd_target_i = tgt;
    @(negedge clk);
    upd_valid_i = 1'b0;
  endtask
  task automatic look(input string name, input logic [31:0] pc, input logic eh, input logic ep, input logic [31:0] en);
    pc_i = pc;
    #1;
    total++;
    if (hit_o !== eh || pred_taken_o !== ep || next_pc_o !== en)
      $display("FAIL %s: got hit=%0b pred=%0b next=%h want hit=%0b pred=%0b next=%h", name, hit_o, pred_taken_o, next_pc_o, eh, ep, en);
    else pass++;
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask
  task automatic test_reset();
    look("reset_lookup", 32'h40, 1'b0, 1'b0, 32'h44);
    @(negedge clk);
    rst = 1'b0;
    look("post_reset_lookup", 32'h40, 1'b0, 1'b0, 32'h44);
  endtask
  task automatic test_counter();
    do_upd(32'h40, 1'b1, 32'h100);
    look("alloc_taken", 32'h40, 1'b1, 1'b1, 32'h100);
    do_upd(32'h40, 1'b0, 32'h0);
    look("ctr_01", 32'h40, 1'b1, 1'b0, 32'h44);
    do_upd(32'h40, 1'b0, 32'h0);
    look("ctr_00", 32'h40, 1'b1, 1'b0, 32'h44);
    do_upd(32'h40, 1'b0, 32'h0);
    do_upd(32'h40, 1'b0, 32'h0);
    look("ctr_00_hold", 32'h40, 1'b1, 1'b0, 32'h44);
    do_upd(32'h40, 1'b1, 32'h120);
    look("ctr_01_after_sat", 32'h40, 1'b1, 1'b0, 32'h44);
    do_upd(32'h40, 1'b1, 32'h120);
    look("ctr_10_new_target", 32'h40, 1'b1, 1'b1, 32'h120);
    for (int i = 0; i < 3; i++) do_upd(32'h40, 1'b1, 32'h100);
    do_upd(32'h40, 1'b0, 32'h0);
    look("ctr_11_hold_then_dec", 32'h40, 1'b1, 1'b1, 32'h100);
  endtask
  task automatic test_alias();
    look("alias_miss", 32'h80, 1'b0, 1'b0, 32'h84);
    do_upd(32'h80, 1'b1, 32'h200);
    look("alias_old_evicted", 32'h40, 1'b0, 1'b0, 32'h44);
    look("alias_new_hit", 32'h80, 1'b1, 1'b1, 32'h200);
    do_upd(32'h1040, 1'b0, 32'h999);
    look("miss_not_taken_nochange", 32'h80, 1'b1, 1'b1, 32'h200);
    look("miss_not_taken_no_alloc", 32'h1040, 1'b0, 1'b0, 32'h1044);
  endtask
  task automatic test_redirect();
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'h300;
    look("redirect_over_pred", 32'h80, 1'b1, 1'b1, 32'h300);
    @(negedge clk);
    redirect_i = 1'b0;
    look("wrap_around", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic test_same_cycle();
    pulse_reset();
    @(negedge clk);
    upd_valid_i = 1'b1; upd_pc_i = 32'h40; upd_taken_i = 1'b1; upd_target_i = 32'h100;
    look("same_cycle_pre", 32'h40, 1'b0, 1'b0, 32'h44);
    @(negedge clk);
    upd_valid_i = 1'b0;
    look("same_cycle_post", 32'h40, 1'b1, 1'b1, 32'h100);
  endtask
  task automatic test_async_reset();
    pulse_reset();
    do_upd(32'h40, 1'b1, 32'h500);
    do_upd(32'h44, 1'b1, 32'h600);
    do_upd(32'h48, 1'b1, 32'h700);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redirect_i = 1'b1; redirect_pc_i = 32'h300;
      @(negedge clk);
      redirect_i = 1'b0;
    end
    look("pre_pulse_hit", 32'h40, 1'b1, 1'b1, 32'h500);
`ifdef BP_STATS_EN
    total++;
    if (stat_upd_cnt_o !== 32'd3 || stat_redir_cnt_o !== 32'd2)
      $display("FAIL stats_before: got upd=%0d redir=%0d want upd=3 redir=2", stat_upd_cnt_o, stat_redir_cnt_o);
    else pass++;
`endif
    @(negedge clk);
    #2 rst = 1'b1;
    look("async_reset_clears", 32'h40, 1'b0, 1'b0, 32'h44);
`ifdef BP_STATS_EN
    total++;
    if (stat_upd_cnt_o !== 32'd0 || stat_redir_cnt_o !== 32'd0)
      $display("FAIL stats_after: got upd=%0d redir=%0d want 0 0", stat_upd_cnt_o, stat_redir_cnt_o);
    else pass++;
`endif
    #1 rst = 1'b0;
    look("after_pulse_still_empty", 32'h48, 1'b0, 1'b0, 32'h4C);
  endtask
  initial begin
    test_reset();
    test_counter();
    test_alias();
    test_redirect();
    test_same_cycle();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Next-PC generator for the fetch stage of the pipelined CPU. Sits directly upstream of the program counter: each cycle it looks up the current fetch PC in a direct-mapped branch target buffer with 2-bit saturating counters and drives the next PC (redirect, predicted target, or PC+4) into the program counter's input. The execute stage updates the table with resolved branch outcomes.

## Interface
Parameters:
- IDX_W, 4: index width; table holds 2^IDX_W entries.
- ADDR_W, 32: PC width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- pc_i  in  ADDR_W  current fetch PC, from the program counter output.
- redirect_i  in  1  mispredict or jump redirect from EX.
- redirect_pc_i  in  ADDR_W  redirect target.
- upd_valid_i  in  1  resolved-branch update strobe.
- upd_pc_i  in  ADDR_W  PC of the resolved branch.
- upd_taken_i  in  1  resolved direction.
- upd_target_i  in  ADDR_W  resolved taken target.
- next_pc_o  out  ADDR_W  next fetch PC, to the program counter input.
- hit_o  out  1  valid entry with matching tag for pc_i.
- pred_taken_o  out  1  hit_o and counter[1].

## Operation
- Entry fields: valid, tag = PC[ADDR_W-1:IDX_W+2], target (ADDR_W), ctr (2 bits). Index = PC[IDX_W+1:2]. PC[1:0] is ignored.
- Lookup is combinational on pc_i:
  - hit_o = valid & tag match.
  - pred_taken_o = hit_o & ctr[1].
  - next_pc_o priority: redirect_i → redirect_pc_i; else pred_taken_o → entry target; else pc_i + 4, modulo 2^ADDR_W.
- Update on the rising edge when upd_valid_i = 1, indexed by upd_pc_i:
  - Hit, taken: ctr saturating +1 (11 holds); target ← upd_target_i.
  - Hit, not taken: ctr saturating −1 (00 holds); target unchanged; entry stays valid.
  - Miss, taken: allocate or replace. valid = 1, tag, target, ctr = 10 (weakly taken).
  - Miss, not taken: no change.
- Updates are independent of redirect_i and of the program counter's write enable. A held PC simply re-looks up the same pc_i.
- Reset: all valid = 0, all ctr = 01, targets = 0. Outputs have no registers of their own. While rst_i = 1 and redirect_i = 0: hit_o = 0, pred_taken_o = 0, next_pc_o = pc_i + 4.

## Timing
- Lookup is zero-latency, combinational from pc_i, redirect_i and redirect_pc_i.
- An update is visible to lookups from the cycle after its clock edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents.
- Reset asserted mid-operation clears all entries immediately, without waiting for a clock edge. The first update takes effect at the first rising edge after rst_i deasserts.
- Wrap-around: pc_i = 0xFFFFFFFC with no predicted taken gives next_pc_o = 0x00000000.

## Configuration
- BP_STATS_EN defined adds two output ports:
  - stat_upd_cnt_o (32 bits): counts cycles with upd_valid_i = 1.
  - stat_redir_cnt_o (32 bits): counts cycles with redirect_i = 1.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are updated on the rising edge.
- BP_STATS_EN undefined: those ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
All scenarios use IDX_W = 4.
- Reset, then pc_i = 0x40 → hit_o = 0, pred_taken_o = 0, next_pc_o = 0x44.
- Update pc 0x40, taken, target 0x100 for one cycle; next cycle pc_i = 0x40 → hit_o = 1, pred_taken_o = 1, next_pc_o = 0x100. Two further not-taken updates → ctr 10 → 01 → 00; pc_i = 0x40 gives hit_o = 1, pred_taken_o = 0, next_pc_o = 0x44. Two more not-taken updates leave ctr at 00.
- Alias: 0x40 is allocated; pc_i = 0x80 (same index, different tag) → hit_o = 0, next_pc_o = 0x84. A taken update at 0x80 with target 0x200 replaces the entry; pc_i = 0x40 now misses and pc_i = 0x80 gives 0x200.
- Redirect priority: with a predicted-taken hit at pc_i, assert redirect_i = 1 with redirect_pc_i = 0x300 → next_pc_o = 0x300. Also pc_i = 0xFFFFFFFC with no hit → next_pc_o = 0x0.
- Same-cycle update and lookup of 0x40 on an empty table → lookup that cycle misses and returns 0x44; the next cycle it hits and returns the target.
- Async reset mid-run: after allocation, pulse rst_i between clock edges → hit_o drops to 0 immediately. With BP_STATS_EN, 3 updates and 2 redirects before the pulse read stat_upd_cnt_o = 3 and stat_redir_cnt_o = 2, and both read 0 after the pulse.
